// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub ALU between NUM_REQ requesters,
// with a one-entry valid/ready response stage. ALU_ARB_STATS_EN adds per-requester grant counters.
module alu_arbiter #(
    parameter  int unsigned SIZE    = 7,
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned W       = SIZE + 1,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [2*NUM_REQ-1:0] req_op_i,
    input  logic [W*NUM_REQ-1:0] req_a_i,
    input  logic [W*NUM_REQ-1:0] req_b_i,
    output logic [1:0]           alu_operator_o,
    output logic [W-1:0]         alu_operand_a_o,
    output logic [W-1:0]         alu_operand_b_o,
    input  logic [W-1:0]         alu_result_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [IDW-1:0]       resp_id_o,
    output logic [W-1:0]         resp_result_o,
    output logic                 resp_err_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0] grant_cnt_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [W-1:0]   resp_result_q, resp_result_d;
    logic           resp_err_q, resp_err_d;

    logic [1:0]     op_arr [NUM_REQ];
    logic [W-1:0]   a_arr  [NUM_REQ];
    logic [W-1:0]   b_arr  [NUM_REQ];

    logic           can_accept;
    logic           grant;
    logic           reserved;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;

    // Split the flat request buses into per-requester fields
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            op_arr[r] = req_op_i[2*r +: 2];
            a_arr[r]  = req_a_i[W*r +: W];
            b_arr[r]  = req_b_i[W*r +: W];
        end
    end

    // Round-robin search: scan downward so the nearest index after rr_q wins
    always_comb begin
        grant      = 1'b0;
        win_id     = '0;
        cand       = '0;
        can_accept = (state_q == EMPTY) || resp_ready_i;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDW'((32'(rr_q) + 32'(i)) % 32'(NUM_REQ));
            if (req_valid_i[cand]) begin
                grant  = 1'b1;
                win_id = cand;
            end
        end
        grant = grant && can_accept && !rst_i;
    end

    // Next state, ALU drive and response capture
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        resp_id_d       = resp_id_q;
        resp_result_d   = resp_result_q;
        resp_err_d      = resp_err_q;
        req_ready_o     = '0;
        alu_operator_o  = 2'b00;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        reserved        = 1'b0;

        if (grant) begin
            reserved            = op_arr[win_id][1];
            req_ready_o[win_id] = 1'b1;
            alu_operator_o      = reserved ? 2'b00 : op_arr[win_id];
            alu_operand_a_o     = a_arr[win_id];
            alu_operand_b_o     = b_arr[win_id];
            resp_result_d       = reserved ? '0 : alu_result_i;
            resp_id_d           = win_id;
            resp_err_d          = reserved;
            rr_d                = win_id;
            state_d             = FULL;
        end else if ((state_q == FULL) && resp_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= EMPTY;
            rr_q          <= IDW'(NUM_REQ - 1);
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign resp_valid_o  = (state_q == FULL);
    assign resp_id_o     = resp_id_q;
    assign resp_result_o = resp_result_q;
    assign resp_err_o    = resp_err_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] grant_cnt_d [NUM_REQ];

    // Saturating per-requester grant counters
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            grant_cnt_d[r] = grant_cnt_q[r];
            if (grant && (win_id == IDW'(r)) && (grant_cnt_q[r] != 16'hFFFF)) begin
                grant_cnt_d[r] = grant_cnt_q[r] + 16'd1;
            end
            grant_cnt_o[16*r +: 16] = grant_cnt_q[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                grant_cnt_q[r] <= '0;
            end
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus predicts grants/responses, a monitor compares responses.
module tb_alu_arbiter;

    localparam int unsigned SIZE    = 7;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned W       = SIZE + 1;
    localparam int unsigned IDW     = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [2*NUM_REQ-1:0] req_op_i;
    logic [W*NUM_REQ-1:0] req_a_i;
    logic [W*NUM_REQ-1:0] req_b_i;
    logic [1:0]           alu_operator_o;
    logic [W-1:0]         alu_operand_a_o;
    logic [W-1:0]         alu_operand_b_o;
    logic [W-1:0]         alu_result_i;
    logic                 resp_valid_o;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id_o;
    logic [W-1:0]         resp_result_o;
    logic                 resp_err_o;
`ifdef ALU_ARB_STATS_EN
    logic [16*NUM_REQ-1:0] grant_cnt_o;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .alu_operator_o (alu_operator_o),
        .alu_operand_a_o(alu_operand_a_o),
        .alu_operand_b_o(alu_operand_b_o),
        .alu_result_i   (alu_result_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready),
        .resp_id_o      (resp_id_o),
        .resp_result_o  (resp_result_o),
        .resp_err_o     (resp_err_o)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt_o    (grant_cnt_o)
`endif
    );

    // Shared ALU the arbiter fronts
    assign alu_result_i = (alu_operator_o == 2'd1) ? alu_operand_a_o - alu_operand_b_o
                                                   : alu_operand_a_o + alu_operand_b_o;

    // Requester-side stimulus state
    logic         v    [NUM_REQ];
    logic [1:0]   op_r [NUM_REQ];
    logic [W-1:0] a_r  [NUM_REQ];
    logic [W-1:0] b_r  [NUM_REQ];
    bit           hold_valid;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_valid_i[r]        = v[r];
            req_op_i[2*r +: 2]    = op_r[r];
            req_a_i[W*r +: W]     = a_r[r];
            req_b_i[W*r +: W]     = b_r[r];
        end
    end

    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit   m_full;
    int   m_rr;
    int   m_cnt [NUM_REQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            default: return '0;
        endcase
    endfunction

    // One clock: predict and check grant/ALU drive, push expected response, advance the model
    task automatic step(output int win, output logic [NUM_REQ-1:0] dut_rdy);
        logic [NUM_REQ-1:0] exp_rdy;
        int c;
        exp_t e;
        @(negedge clk);
        win = -1;
        check("resp_valid", 64'(resp_valid_o), 64'(m_full));
        if (!rst && (!m_full || resp_ready)) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (m_rr + k) % NUM_REQ;
                if (win < 0 && v[c]) win = c;
            end
        end
        exp_rdy = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
        dut_rdy = req_ready_o;
        check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        if (win >= 0) begin
            check("alu_drive", 64'({alu_operator_o, alu_operand_a_o, alu_operand_b_o}),
                  64'({(op_r[win] < 2'd2) ? op_r[win] : 2'd0, a_r[win], b_r[win]}));
            e.id  = win;
            e.res = ref_result(op_r[win], a_r[win], b_r[win]);
            e.err = (op_r[win] >= 2'd2);
            sbq.push_back(e);
        end else begin
            check("alu_idle", 64'({alu_operator_o, alu_operand_a_o, alu_operand_b_o}), 64'(0));
        end
        if (rst) begin
            m_full = 1'b0;
            m_rr   = NUM_REQ - 1;
            sbq.delete();
            for (int r = 0; r < NUM_REQ; r++) m_cnt[r] = 0;
        end else if (win >= 0) begin
            m_full = 1'b1;
            m_rr   = win;
            if (m_cnt[win] < 65535) m_cnt[win]++;
        end else if (m_full && resp_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        if (win >= 0 && !hold_valid) v[win] = 1'b0;
    endtask

    // Monitor: whenever a response is presented it must match the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && resp_valid_o === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got id %0d result %0h, expected no response",
                             resp_id_o, resp_result_o);
                end else begin
                    mon_e = sbq[0];
                    check("resp_id", 64'(resp_id_o), 64'(mon_e.id));
                    check("resp_result", 64'(resp_result_o), 64'(mon_e.res));
                    check("resp_err", 64'(resp_err_o), 64'(mon_e.err));
                    if (resp_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic set_req(input int r, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        v[r] = 1'b1; op_r[r] = op; a_r[r] = a; b_r[r] = b;
    endtask

    int                 w;
    logic [NUM_REQ-1:0] rdy;
    int                 exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int r = 0; r < NUM_REQ; r++) begin
            v[r] = 1'b0; op_r[r] = '0; a_r[r] = '0; b_r[r] = '0; m_cnt[r] = 0;
        end
        hold_valid = 1'b0;
        m_full     = 1'b0;
        m_rr       = NUM_REQ - 1;
        resp_ready = 1'b1;
        rst        = 1'b1;

        // Reset with a request already pending: no grant while in reset
        set_req(0, 2'd0, 8'h05, 8'h03);
        step(w, rdy);
        step(w, rdy);
        rst = 1'b0;
        check("rst_state", 64'({resp_valid_o, resp_id_o, resp_result_o, resp_err_o}), 64'(0));

        // Basic add
        step(w, rdy);
        check("t1_result", 64'({resp_valid_o, resp_id_o, resp_result_o}), 64'({1'b1, 2'd0, 8'h08}));

        // Subtract with borrow wrap, add with carry wrap
        set_req(1, 2'd1, 8'h02, 8'h05);
        step(w, rdy);
        check("t2_sub", 64'({resp_id_o, resp_result_o, resp_err_o}), 64'({2'd1, 8'hFD, 1'b0}));
        set_req(0, 2'd0, 8'hFF, 8'h01);
        step(w, rdy);
        check("t2_add_wrap", 64'(resp_result_o), 64'(8'h00));

        // Fresh reset, then all four contending: rotation 0,1,2,3,0
        rst = 1'b1;
        step(w, rdy);
        rst = 1'b0;
        hold_valid = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) set_req(r, 2'(r % 2), 8'(8'h10 * r + 1), 8'(r + 2));
        for (int k = 0; k < 5; k++) begin
            step(w, rdy);
            check("t3_rotation", 64'(rdy), 64'(NUM_REQ'(1) << exp_order[k]));
        end
        hold_valid = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) v[r] = 1'b0;

        // Back-pressure: response held, no accepts; release gives same-cycle accept
        set_req(2, 2'd1, 8'h40, 8'h01);
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(w, rdy);
            check("t4_stall_ready", 64'(rdy), 64'(0));
        end
        resp_ready = 1'b1;
        step(w, rdy);
        check("t4_release_accept", 64'(rdy), 64'(4'b0100));
        check("t4_new_resp", 64'({resp_id_o, resp_result_o}), 64'({2'd2, 8'h3F}));

        // Reserved op flags error and zeroes result; next legal op clears it
        set_req(3, 2'd2, 8'h11, 8'h22);
        step(w, rdy);
        check("t5_reserved", 64'({resp_id_o, resp_result_o, resp_err_o}), 64'({2'd3, 8'h00, 1'b1}));
        set_req(3, 2'd0, 8'h11, 8'h22);
        step(w, rdy);
        check("t5_err_clear", 64'({resp_result_o, resp_err_o}), 64'({8'h33, 1'b0}));

        // Reset while FULL drops the response; requester 0 wins afterwards
        set_req(1, 2'd0, 8'h01, 8'h01);
        rst = 1'b1;
        step(w, rdy);
        rst = 1'b0;
        check("t6_dropped", 64'(resp_valid_o), 64'(0));
        set_req(0, 2'd1, 8'h09, 8'h04);
        step(w, rdy);
        check("t6_req0_first", 64'(rdy), 64'(4'b0001));

        // Randomized traffic with random back-pressure and rare resets
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!v[r] && $urandom_range(0, 2) == 0) begin
                    set_req(r, ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1))
                                                          : 2'($urandom_range(2, 3)),
                            8'($urandom), 8'($urandom));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 499) == 0);
            step(w, rdy);
        end
        rst = 1'b0;

        // Drain outstanding responses
        for (int r = 0; r < NUM_REQ; r++) v[r] = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) step(w, rdy);
        check("drain_empty", 64'(sbq.size()), 64'(0));

`ifdef ALU_ARB_STATS_EN
        for (int r = 0; r < NUM_REQ; r++) begin
            check("cnt_random", 64'(grant_cnt_o[16*r +: 16]), 64'(m_cnt[r]));
        end
        rst = 1'b1;
        step(w, rdy);
        rst = 1'b0;
        check("cnt_reset", 64'(grant_cnt_o), 64'(0));
        hold_valid = 1'b1;
        set_req(0, 2'd0, 8'h01, 8'h02);
        for (int n = 0; n < 70000; n++) step(w, rdy);
        hold_valid = 1'b0;
        v[0] = 1'b0;
        step(w, rdy);
        check("cnt_saturate", 64'(grant_cnt_o[15:0]), 64'(16'hFFFF));
        for (int r = 0; r < NUM_REQ; r++) begin
            check("cnt_model", 64'(grant_cnt_o[16*r +: 16]), 64'(m_cnt[r]));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
